// File: rtl/mfp_timer_gen_if.sv
// mfp_timer_gen_if: register-access signals between the MFP bus decoder and one timer channel.
// Signal directions are named from the timer channel's point of view.
interface mfp_timer_gen_if #(
   parameter int W = 8
);
   logic         i_ds;
   logic         i_dat_we;
   logic [W-1:0] i_dat;
   logic [W-1:0] o_dat;
   logic         i_ctrl_we;
   logic [6:0]   i_ctrl;
   logic [5:0]   o_ctrl;

   modport master (
      output i_ds, i_dat_we, i_dat, i_ctrl_we, i_ctrl,
      input  o_dat, o_ctrl
   );

   modport slave (
      input  i_ds, i_dat_we, i_dat, i_ctrl_we, i_ctrl,
      output o_dat, o_ctrl
   );
endinterface

// File: rtl/mfp_timer_gen.sv
// mfp_timer_gen: MFP-style W-bit down-counting timer channel (delay/event/pulse/one-shot modes).
// Define MFP_TIMER_CASCADE_EN to let control[5] make the channel count CASC_I pulses.
module mfp_timer_gen #(
   parameter int W          = 8,
   parameter int TRIG_DEPTH = 8,
   parameter int TRIG_TAP   = 2
) (
   input  logic           clk,
   input  logic           rst_n,
   mfp_timer_gen_if.slave bus,
   input  logic           i_xclk_en,
   input  logic           i_t_i,
   input  logic           i_casc_i,
   output logic           o_pulse_mode,
   output logic           o_event_mode,
   output logic           o_running,
   output logic           o_t_o,
   output logic           o_t_o_pulse,
   output logic [W-1:0]   o_set_data_out
);

`ifdef MFP_TIMER_CASCADE_EN
   localparam logic [5:0] CTRL_MASK = 6'h3F;
`else
   localparam logic [5:0] CTRL_MASK = 6'h1F;
`endif

   logic [5:0]            r_ctrl;
   logic [W-1:0]          r_data;
   logic [W-1:0]          r_cnt;
   logic [W-1:0]          r_snap;
   logic [7:0]            r_presc;
   logic [TRIG_DEPTH-1:0] r_filt;
   logic                  r_cnt_en;
   logic                  r_reload;
   logic                  r_ds_q;
   logic                  r_to;
   logic                  r_to_pulse;

   logic       w_running;
   logic       w_delay;
   logic       w_event;
   logic       w_pulse;
   logic       w_casc_on;
   logic [7:0] w_div_m1;
   logic       w_tick;
   logic       w_trig;
   logic       w_src;
   logic       w_reload;
   logic       w_dat_load;
   logic       w_dec;
   logic       w_timeout;

   assign w_running = |r_ctrl[3:0];
   assign w_delay   = ~r_ctrl[3] & (|r_ctrl[2:0]);
   assign w_event   = (r_ctrl[3:0] == 4'b1000);
   assign w_pulse   = r_ctrl[3] & (|r_ctrl[2:0]);

   // control[5] only ever becomes set when the cascade build stores it
   assign w_casc_on = r_ctrl[5] & w_running;

   always_comb begin
      w_div_m1 = 8'd0;
      case (r_ctrl[2:0])
         3'd1:    w_div_m1 = 8'd3;
         3'd2:    w_div_m1 = 8'd9;
         3'd3:    w_div_m1 = 8'd15;
         3'd4:    w_div_m1 = 8'd49;
         3'd5:    w_div_m1 = 8'd63;
         3'd6:    w_div_m1 = 8'd99;
         3'd7:    w_div_m1 = 8'd199;
         default: w_div_m1 = 8'd0;
      endcase
   end

   // The 199 cap bounds the first tick after a divisor is lowered mid-count
   assign w_tick = i_xclk_en & (|r_ctrl[2:0]) & ((r_presc == w_div_m1) | (r_presc == 8'd199));
   assign w_trig = i_xclk_en & (r_filt[TRIG_TAP+3:TRIG_TAP] == 4'b0011);

   always_comb begin
      w_src = 1'b0;
      if (w_casc_on)    w_src = i_casc_i;
      else if (w_pulse) w_src = w_tick & w_trig;
      else if (w_delay) w_src = w_tick;
      else if (w_event) w_src = w_trig;
   end

   assign w_dat_load = bus.i_dat_we & ~w_running;
   assign w_reload   = r_reload & w_running;
   assign w_dec      = r_cnt_en & w_running & ~w_reload;
   assign w_timeout  = w_dec & (r_cnt == W'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ctrl     <= '0;
         r_data     <= '0;
         r_cnt      <= '0;
         r_snap     <= '0;
         r_presc    <= '0;
         r_filt     <= '0;
         r_cnt_en   <= 1'b0;
         r_reload   <= 1'b0;
         r_ds_q     <= 1'b0;
         r_to       <= 1'b0;
         r_to_pulse <= 1'b0;
      end else begin
         r_ds_q <= bus.i_ds;
         if (bus.i_ds && !r_ds_q) r_snap <= r_cnt;

         if (i_xclk_en) r_filt <= (r_filt << 1) | {{(TRIG_DEPTH-1){1'b0}}, i_t_i};

         if (r_ctrl[2:0] == 3'd0)  r_presc <= 8'd0;
         else if (i_xclk_en)       r_presc <= w_tick ? 8'd0 : r_presc + 8'd1;

         r_cnt_en   <= w_src;
         r_reload   <= w_timeout;
         r_to_pulse <= w_timeout;

         if (bus.i_dat_we) r_data <= bus.i_dat;

         // A one-shot timeout parks the counter at the data value since the later reload is suppressed
         if (w_dat_load)     r_cnt <= bus.i_dat;
         else if (w_reload)  r_cnt <= r_data;
         else if (w_dec)     r_cnt <= (w_timeout && r_ctrl[4]) ? r_data : r_cnt - W'(1);

         if (bus.i_ctrl_we)              r_ctrl      <= bus.i_ctrl[5:0] & CTRL_MASK;
         else if (w_timeout && r_ctrl[4]) r_ctrl[3:0] <= 4'b0000;

         if (bus.i_ctrl_we && bus.i_ctrl[6]) r_to <= 1'b0;
         else if (w_timeout)                 r_to <= ~r_to;
      end
   end

   assign bus.o_dat      = r_snap;
   assign bus.o_ctrl     = r_ctrl;
   assign o_pulse_mode   = w_pulse;
   assign o_event_mode   = w_event;
   assign o_running      = w_running;
   assign o_t_o          = r_to;
   assign o_t_o_pulse    = r_to_pulse;
   assign o_set_data_out = r_data;

endmodule
